// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared constants for the missionaries/cannibals run controller
//
// Contents:
//   ctrl_state_e   3-bit controller state encoding (IDLE..FAULT)
//   FC_*           2-bit fault codes
//   ENG_*          4-bit engine state constants IDLE..S12
//   TOTAL          missionaries (and cannibals) per puzzle
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_RUN       = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_STEP_WAIT = 3'd4,
        ST_CHECK     = 3'd5,
        ST_DONE      = 3'd6,
        ST_FAULT     = 3'd7
    } ctrl_state_e;

    localparam logic [1:0] FC_NONE         = 2'd0;
    localparam logic [1:0] FC_CONSERVATION = 2'd1;
    localparam logic [1:0] FC_UNSAFE       = 2'd2;
    localparam logic [1:0] FC_SEQUENCE     = 2'd3;

    localparam logic [3:0] ENG_IDLE = 4'd0;
    localparam logic [3:0] ENG_S1   = 4'd1;
    localparam logic [3:0] ENG_S2   = 4'd2;
    localparam logic [3:0] ENG_S3   = 4'd3;
    localparam logic [3:0] ENG_S4   = 4'd4;
    localparam logic [3:0] ENG_S5   = 4'd5;
    localparam logic [3:0] ENG_S6   = 4'd6;
    localparam logic [3:0] ENG_S7   = 4'd7;
    localparam logic [3:0] ENG_S8   = 4'd8;
    localparam logic [3:0] ENG_S9   = 4'd9;
    localparam logic [3:0] ENG_S10  = 4'd10;
    localparam logic [3:0] ENG_S11  = 4'd11;
    localparam logic [3:0] ENG_S12  = 4'd12;

    localparam int unsigned TOTAL = 3;

endpackage

// File: rtl/mc_rule_checker.sv
// rtl/mc_rule_checker.sv - combinational puzzle rule check for one engine move
//
// Ports:
//   m_left, c_left, m_right, c_right  bank counts after the move
//   boat, boat_prev                   boat side after / before the move
//   valid, done                       engine valid_state / solution_complete
//   step_num                          1-based number of the move just made
//   pass                              1 when no rule is broken
//   code                              first failing rule (FC_* priority order)
module mc_rule_checker
    import mc_pkg::*;
#(
    parameter int unsigned MOVES = 12
) (
    input  logic [2:0] m_left,
    input  logic [2:0] c_left,
    input  logic [2:0] m_right,
    input  logic [2:0] c_right,
    input  logic       boat,
    input  logic       boat_prev,
    input  logic       valid,
    input  logic       done,
    input  logic [3:0] step_num,
    output logic       pass,
    output logic [1:0] code
);

    logic [3:0] m_sum;
    logic [3:0] c_sum;
    logic       first_move;
    logic       last_move;
    logic       boat_bad;
    logic       cons_bad;
    logic       unsafe_bad;
    logic       seq_bad;

    assign m_sum = {1'b0, m_left} + {1'b0, m_right};
    assign c_sum = {1'b0, c_left} + {1'b0, c_right};

    assign first_move = (step_num == 4'd1);
    assign last_move  = (step_num == 4'(MOVES));

    // Leaving engine IDLE loads the boat without crossing; every later move crosses.
    assign boat_bad = first_move ? (boat != boat_prev) : (boat == boat_prev);

    assign cons_bad   = (m_sum != 4'(TOTAL)) || (c_sum != 4'(TOTAL));
    assign unsafe_bad = ((m_left != 3'd0) && (m_left < c_left)) ||
                        ((m_right != 3'd0) && (m_right < c_right));
    assign seq_bad    = !valid || boat_bad || (done && !last_move) || (last_move && !done);

    always_comb begin
        code = FC_NONE;
        if (cons_bad) begin
            code = FC_CONSERVATION;
        end else if (unsafe_bad) begin
            code = FC_UNSAFE;
        end else if (seq_bad) begin
            code = FC_SEQUENCE;
        end
    end

    assign pass = (code == FC_NONE);

endmodule

// File: rtl/mc_run_controller.sv
// rtl/mc_run_controller.sv - run sequencer and move checker for the puzzle engine
//
// Optional feature macro: MC_AUTO_LOOP_EN (DONE auto-restarts after HOLD_TICKS ticks)
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   btn_start/step/pause/restart    one-cycle debounced button pulses
//   mode_auto                       1 = tick-paced run, 0 = manual step (sampled at start)
//   eng_m_left..eng_c_right         engine bank counts
//   eng_boat, eng_done, eng_valid   engine boat side, solution_complete, valid_state
//   eng_reset, eng_start            engine reset / start pulses
//   eng_step_en                     one-cycle move enable to the engine
//   ctrl_state                      current controller state encoding
//   step_count                      moves issued in this run
//   fault, fault_code               sticky fault flag and first failing rule
//   busy                            run in progress (ARMED..CHECK)
module mc_run_controller
    import mc_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned CNT_W      = 26,
    parameter int unsigned MOVES      = 12,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_step,
    input  logic       btn_pause,
    input  logic       btn_restart,
    input  logic       mode_auto,
    input  logic [2:0] eng_m_left,
    input  logic [2:0] eng_c_left,
    input  logic [2:0] eng_m_right,
    input  logic [2:0] eng_c_right,
    input  logic       eng_boat,
    input  logic       eng_done,
    input  logic       eng_valid,
    output logic       eng_reset,
    output logic       eng_start,
    output logic       eng_step_en,
    output logic [2:0] ctrl_state,
    output logic [3:0] step_count,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       busy
);

    ctrl_state_e      state;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick_wrap;
    logic             mode_lat;
    logic             boat_prev;
    logic             restart_ok;
    logic             chk_pass;
    logic [1:0]       chk_code;
    logic [3:0]       step_num;

`ifdef MC_AUTO_LOOP_EN
    logic [7:0]       hold_cnt;
    logic             relaunch;
`else
    logic             unused_hold;
    assign unused_hold = (HOLD_TICKS != 0);
`endif

    assign tick_wrap  = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign restart_ok = btn_restart && (state != ST_IDLE);
    assign step_num   = step_count + 4'd1;

    // The move enable is decoded in the same cycle as the triggering event so the
    // engine advances on that edge and CHECK (next cycle) sees the post-move state.
    assign eng_step_en = !btn_restart &&
                         (((state == ST_RUN) && !btn_pause && tick_wrap) ||
                          ((state == ST_STEP_WAIT) && btn_step));

    assign ctrl_state = state;
    assign busy       = (state == ST_ARMED) || (state == ST_RUN) || (state == ST_PAUSED) ||
                        (state == ST_STEP_WAIT) || (state == ST_CHECK);

    mc_rule_checker #(
        .MOVES(MOVES)
    ) u_rule_checker (
        .m_left   (eng_m_left),
        .c_left   (eng_c_left),
        .m_right  (eng_m_right),
        .c_right  (eng_c_right),
        .boat     (eng_boat),
        .boat_prev(boat_prev),
        .valid    (eng_valid),
        .done     (eng_done),
        .step_num (step_num),
        .pass     (chk_pass),
        .code     (chk_code)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            mode_lat   <= 1'b0;
            boat_prev  <= 1'b0;
            eng_reset  <= 1'b1;
            eng_start  <= 1'b0;
            step_count <= 4'd0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
`ifdef MC_AUTO_LOOP_EN
            hold_cnt   <= 8'd0;
            relaunch   <= 1'b0;
`endif
        end else begin
            eng_reset <= 1'b0;
            eng_start <= 1'b0;

            // Boat side before the move, for the toggle rule.
            if (eng_step_en) begin
                boat_prev <= eng_boat;
            end

            if (restart_ok) begin
                eng_reset  <= 1'b1;
                fault      <= 1'b0;
                fault_code <= FC_NONE;
                step_count <= 4'd0;
                tick_cnt   <= '0;
                state      <= ST_IDLE;
`ifdef MC_AUTO_LOOP_EN
                hold_cnt   <= 8'd0;
                relaunch   <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
`ifdef MC_AUTO_LOOP_EN
                        // Internal restart keeps the previously latched mode.
                        if (relaunch) begin
                            relaunch   <= 1'b0;
                            eng_start  <= 1'b1;
                            step_count <= 4'd0;
                            tick_cnt   <= '0;
                            state      <= ST_ARMED;
                        end else
`endif
                        if (btn_start) begin
                            eng_start  <= 1'b1;
                            step_count <= 4'd0;
                            mode_lat   <= mode_auto;
                            tick_cnt   <= '0;
                            state      <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        state <= mode_lat ? ST_RUN : ST_STEP_WAIT;
                    end
                    ST_RUN: begin
                        if (btn_pause) begin
                            state <= ST_PAUSED;
                        end else if (tick_wrap) begin
                            tick_cnt <= '0;
                            state    <= ST_CHECK;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    ST_PAUSED: begin
                        if (btn_pause) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_STEP_WAIT: begin
                        if (btn_step) begin
                            state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        step_count <= step_num;
                        tick_cnt   <= '0;
                        if (!chk_pass) begin
                            fault      <= 1'b1;
                            fault_code <= chk_code;
                            state      <= ST_FAULT;
                        end else if (eng_done) begin
                            state <= ST_DONE;
                        end else begin
                            state <= mode_lat ? ST_RUN : ST_STEP_WAIT;
                        end
                    end
                    ST_DONE: begin
`ifdef MC_AUTO_LOOP_EN
                        if (tick_wrap) begin
                            tick_cnt <= '0;
                            if (hold_cnt == 8'(HOLD_TICKS - 1)) begin
                                hold_cnt   <= 8'd0;
                                eng_reset  <= 1'b1;
                                step_count <= 4'd0;
                                relaunch   <= 1'b1;
                                state      <= ST_IDLE;
                            end else begin
                                hold_cnt <= hold_cnt + 8'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
`endif
                    end
                    ST_FAULT: begin
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mc_run_controller.sv
// tb/tb_mc_run_controller.sv - directed self-checking bench for mc_run_controller
module tb_mc_run_controller;
    import mc_pkg::*;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned MOVES      = 12;
    localparam int unsigned HOLD_TICKS = 2;

    localparam logic [3:0] B_START   = 4'b0001;
    localparam logic [3:0] B_STEP    = 4'b0010;
    localparam logic [3:0] B_PAUSE   = 4'b0100;
    localparam logic [3:0] B_RESTART = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start, btn_step, btn_pause, btn_restart, mode_auto;
    logic [2:0] m_l, c_l, m_r, c_r;
    logic       boat, done, valid;
    logic       eng_reset, eng_start, eng_step_en, fault, busy;
    logic [2:0] ctrl_state;
    logic [3:0] step_count;
    logic [1:0] fault_code;

    always #5 clk = ~clk;

    mc_run_controller #(
        .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .MOVES(MOVES), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_start(btn_start), .btn_step(btn_step), .btn_pause(btn_pause),
        .btn_restart(btn_restart), .mode_auto(mode_auto),
        .eng_m_left(m_l), .eng_c_left(c_l), .eng_m_right(m_r), .eng_c_right(c_r),
        .eng_boat(boat), .eng_done(done), .eng_valid(valid),
        .eng_reset(eng_reset), .eng_start(eng_start), .eng_step_en(eng_step_en),
        .ctrl_state(ctrl_state), .step_count(step_count),
        .fault(fault), .fault_code(fault_code), .busy(busy)
    );

    // Engine model: standard 11-crossing solution preceded by a boat-loading move.
    int   tbl_m [13] = '{3, 3, 3, 3, 3, 3, 1, 2, 0, 0, 0, 0, 0};
    int   tbl_c [13] = '{3, 3, 1, 2, 0, 1, 1, 2, 2, 3, 1, 2, 0};
    logic tbl_b [13] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int   eng_idx = 0;
    int   ovr = 0;

    always @(posedge clk) begin
        if (eng_reset) eng_idx <= 0;
        else if (eng_step_en && eng_idx < 12) eng_idx <= eng_idx + 1;
    end

    always_comb begin
        m_l   = 3'(tbl_m[eng_idx]);
        c_l   = 3'(tbl_c[eng_idx]);
        m_r   = 3'(3 - tbl_m[eng_idx]);
        c_r   = 3'(3 - tbl_c[eng_idx]);
        boat  = tbl_b[eng_idx];
        done  = (eng_idx == 12);
        valid = 1'b1;
        if (ovr == 1 && eng_idx == 3) begin
            m_l = 3'd1; c_l = 3'd2; m_r = 3'd2; c_r = 3'd1;
        end
        if (ovr == 2 && eng_idx == 1) begin
            m_r = 3'd1; c_r = 3'd1; valid = 1'b0;
        end
        if (ovr == 3 && eng_idx == 1) done = 1'b1;
    end

    // Pulse monitor, sampled mid-cycle.
    int cyc = 0;
    int n_step = 0, n_rst = 0, n_start = 0, back_to_back = 0;
    int last_step_cyc = -1, gap_min = 1000, gap_max = 0;
    logic prev_step = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (eng_step_en) begin
            if (prev_step) back_to_back++;
            if (last_step_cyc >= 0) begin
                if (cyc - last_step_cyc < gap_min) gap_min = cyc - last_step_cyc;
                if (cyc - last_step_cyc > gap_max) gap_max = cyc - last_step_cyc;
            end
            last_step_cyc = cyc;
            n_step++;
        end
        prev_step = eng_step_en;
        if (eng_reset) n_rst++;
        if (eng_start) n_start++;
    end

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] b);
        {btn_restart, btn_pause, btn_step, btn_start} = b;
        wait_cyc(1);
        {btn_restart, btn_pause, btn_step, btn_start} = 4'b0000;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (ctrl_state !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ctrl_state), 32'(st));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n0, s0, r0;

    initial begin
        reset = 1'b1;
        {btn_restart, btn_pause, btn_step, btn_start} = 4'b0000;
        mode_auto = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        check("rst_eng_reset", 32'(eng_reset), 1);
        check("rst_state", 32'(ctrl_state), 0);
        check("rst_step_count", 32'(step_count), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_fault_code", 32'(fault_code), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_eng_start", 32'(eng_start), 0);
        check("rst_step_en", 32'(eng_step_en), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("eng_reset_after_release", 32'(eng_reset), 1);
        @(negedge clk);
        check("eng_reset_cleared", 32'(eng_reset), 0);
        @(posedge clk); #1;

        // Manual run of 12 moves.
        mode_auto = 1'b0;
        n0 = n_step;
        press(B_START);
        @(negedge clk);
        check("man_eng_start", 32'(eng_start), 1);
        check("man_armed", 32'(ctrl_state), 1);
        check("man_busy", 32'(busy), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("man_step_wait", 32'(ctrl_state), 4);
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            press(B_STEP);
            wait_cyc(1);
        end
        @(negedge clk);
        check("man_pulses", 32'(n_step - n0), 12);
        check("man_step_count", 32'(step_count), 12);
        check("man_done", 32'(ctrl_state), 6);
        check("man_fault", 32'(fault), 0);
        check("man_busy_done", 32'(busy), 0);
        check("man_no_back_to_back", 32'(back_to_back), 0);
        @(posedge clk); #1;
        press(B_START);
        @(negedge clk);
        check("start_ignored_in_done", 32'(ctrl_state), 6);
        @(posedge clk); #1;
        press(B_RESTART);
        @(negedge clk);
        check("man_restart_eng_reset", 32'(eng_reset), 1);
        check("man_restart_idle", 32'(ctrl_state), 0);
        check("man_restart_count", 32'(step_count), 0);
        @(posedge clk); #1;

        // Auto-paced run; mode_auto dropped after start to show it is latched.
        mode_auto = 1'b1;
        gap_min = 1000; gap_max = 0; last_step_cyc = -1;
        n0 = n_step;
        press(B_START);
        mode_auto = 1'b0;
        wait_state("auto_reach_done", 3'd6, 200);
        check("auto_pulses", 32'(n_step - n0), 12);
        check("auto_gap_min", 32'(gap_min), 5);
        check("auto_gap_max", 32'(gap_max), 5);
        check("auto_step_count", 32'(step_count), 12);
        check("auto_fault", 32'(fault), 0);
        s0 = n_start;
        r0 = n_rst;
`ifdef MC_AUTO_LOOP_EN
        wait_cyc(12);
        @(negedge clk);
        check("loop_eng_reset", 32'(n_rst - r0), 1);
        check("loop_eng_start", 32'(n_start - s0), 1);
        check("loop_busy", 32'(busy), 1);
`else
        wait_cyc(20);
        @(negedge clk);
        check("done_holds", 32'(ctrl_state), 6);
        check("done_no_start", 32'(n_start - s0), 0);
`endif
        @(posedge clk); #1;
        press(B_RESTART);
        @(negedge clk);
        check("auto_restart_idle", 32'(ctrl_state), 0);
        @(posedge clk); #1;

        // Pause at counter value 2.
        mode_auto = 1'b1;
        n0 = n_step;
        press(B_START);
        wait_cyc(3);
        press(B_PAUSE);
        check("pause_no_early_step", 32'(n_step - n0), 0);
        n0 = n_step;
        wait_cyc(20);
        @(negedge clk);
        check("pause_no_step", 32'(n_step - n0), 0);
        check("pause_state", 32'(ctrl_state), 3);
        check("pause_busy", 32'(busy), 1);
        @(posedge clk); #1;
        press(B_PAUSE);
        @(negedge clk);
        check("resume_state", 32'(ctrl_state), 2);
        check("resume_step_1", 32'(eng_step_en), 0);
        @(negedge clk);
        check("resume_step_2", 32'(eng_step_en), 1);
        @(posedge clk); #1;
        press(B_RESTART);
        mode_auto = 1'b0;

        // Unsafe bank after move 3.
        ovr = 1;
        press(B_START);
        wait_cyc(1);
        for (int i = 0; i < 3; i++) begin
            press(B_STEP);
            wait_cyc(1);
        end
        @(negedge clk);
        check("unsafe_state", 32'(ctrl_state), 7);
        check("unsafe_fault", 32'(fault), 1);
        check("unsafe_code", 32'(fault_code), 2);
        check("unsafe_count", 32'(step_count), 3);
        n0 = n_step;
        @(posedge clk); #1;
        press(B_STEP);
        press(B_PAUSE);
        wait_cyc(4);
        @(negedge clk);
        check("unsafe_no_more_steps", 32'(n_step - n0), 0);
        check("unsafe_held", 32'(fault_code), 2);
        @(posedge clk); #1;
        press(B_RESTART);
        @(negedge clk);
        check("unsafe_clear_fault", 32'(fault), 0);
        check("unsafe_clear_code", 32'(fault_code), 0);
        @(posedge clk); #1;

        // Conservation beats sequence.
        ovr = 2;
        press(B_START);
        wait_cyc(1);
        press(B_STEP);
        wait_cyc(1);
        @(negedge clk);
        check("cons_code", 32'(fault_code), 1);
        check("cons_state", 32'(ctrl_state), 7);
        @(posedge clk); #1;
        press(B_RESTART);
        @(negedge clk);
        check("cons_restart_pulse", 32'(eng_reset), 1);
        check("cons_restart_fault", 32'(fault), 0);
        check("cons_restart_idle", 32'(ctrl_state), 0);
        @(posedge clk); #1;

        // Premature done is a sequence fault.
        ovr = 3;
        press(B_START);
        wait_cyc(1);
        press(B_STEP);
        wait_cyc(1);
        @(negedge clk);
        check("seq_code", 32'(fault_code), 3);
        @(posedge clk); #1;
        press(B_RESTART);
        ovr = 0;

        // Restart and step together in STEP_WAIT.
        press(B_START);
        wait_cyc(1);
        n0 = n_step;
        btn_restart = 1'b1;
        btn_step = 1'b1;
        @(negedge clk);
        check("prio_in_step_wait", 32'(ctrl_state), 4);
        check("prio_no_step_en", 32'(eng_step_en), 0);
        @(posedge clk); #1;
        btn_restart = 1'b0;
        btn_step = 1'b0;
        @(negedge clk);
        check("prio_eng_reset", 32'(eng_reset), 1);
        check("prio_idle", 32'(ctrl_state), 0);
        check("prio_no_pulse", 32'(n_step - n0), 0);
        check("no_back_to_back_overall", 32'(back_to_back), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_run_controller.md
Name: mc_run_controller

Overview:
Sequencer and checker for the missionaries/cannibals puzzle engine, the 4-bit T-flip-flop state machine with 12 solution moves. The block issues the engine's reset, start and per-move step enable in one of two modes: auto, paced by a tick divider, or manual single-step. After every move it checks the engine's bank counts against the puzzle rules and latches a fault if any rule is broken. It sits between board buttons and switches (already debounced and synchronised) and the engine plus display logic.

Parameters:
- TICK_DIV, 50000000: clk cycles between auto steps. Must be ≥2.
- CNT_W, 26: width of the tick counter. Must satisfy 2^CNT_W > TICK_DIV.
- MOVES, 12: number of moves from engine IDLE to solved.
- HOLD_TICKS, 4: ticks spent in DONE before auto-restart (used only with MC_AUTO_LOOP_EN).

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high.
- btn_start, in, 1: one-cycle pulse; begins a run.
- btn_step, in, 1: one-cycle pulse; manual move request.
- btn_pause, in, 1: one-cycle pulse; toggles RUN/PAUSED.
- btn_restart, in, 1: one-cycle pulse; aborts the run and restarts the engine.
- mode_auto, in, 1: 1 = auto pacing, 0 = manual step. Sampled when a run starts.
- eng_m_left, eng_c_left, eng_m_right, eng_c_right, in, 3 each: engine bank counts.
- eng_boat, in, 1: engine boat side (0 = left, 1 = right).
- eng_done, in, 1: engine solution_complete.
- eng_valid, in, 1: engine valid_state.
- eng_reset, out, 1: synchronous reset pulse to the engine.
- eng_start, out, 1: start pulse to the engine.
- eng_step_en, out, 1: one-cycle move enable to the engine.
- ctrl_state, out, 3: current FSM state encoding.
- step_count, out, 4: moves issued in the current run.
- fault, out, 1: sticky fault flag.
- fault_code, out, 2: 0 = none, 1 = conservation, 2 = unsafe bank, 3 = sequence.
- busy, out, 1: high in ARMED, RUN, PAUSED, STEP_WAIT and CHECK.

Behaviour:
- Reset values: all outputs 0, except eng_reset = 1 while reset is asserted and for one cycle after release. FSM starts in IDLE; tick counter is 0.
- States and encodings: IDLE=0, ARMED=1, RUN=2, PAUSED=3, STEP_WAIT=4, CHECK=5, DONE=6, FAULT=7.
- IDLE: on btn_start, drive eng_start for 1 cycle, clear step_count, latch mode_auto, go to ARMED.
- ARMED: after one cycle, go to RUN if auto mode was latched, else STEP_WAIT.
- RUN: tick counter counts 0..TICK_DIV-1 and wraps. On wrap, drive eng_step_en for 1 cycle and go to CHECK. btn_pause goes to PAUSED and the counter holds its value.
- PAUSED: btn_pause returns to RUN; the counter resumes from the held value.
- STEP_WAIT: on btn_step, drive eng_step_en and go to CHECK.
- CHECK: lasts exactly 1 cycle; the engine outputs already reflect the new state. In this cycle:
  - increment step_count;
  - evaluate the rules below in priority order and latch the first failure:
    - conservation: m_left+m_right ≠ 3 or c_left+c_right ≠ 3 → code 1;
    - unsafe bank: either bank has M>0 and M<C → code 2;
    - sequence: any of the following → code 3:
      - eng_valid = 0;
      - boat did not toggle versus the pre-step value (the first move from engine IDLE must leave the boat unchanged);
      - eng_done = 1 with step_count+1 ≠ MOVES;
      - step_count+1 = MOVES with eng_done = 0.
  - Next state: FAULT on any failure; else DONE if eng_done; else back to RUN (counter reset to 0) or STEP_WAIT.
- DONE: busy = 0; hold until btn_restart.
- FAULT: fault = 1 and fault_code are held; only btn_restart or reset leaves this state.
- btn_restart, accepted in any state except IDLE: pulse eng_reset for 1 cycle, clear fault, fault_code, step_count and the counter, go to IDLE.
- Event priority in the same cycle: btn_restart > btn_pause > btn_step > tick wrap.
  - btn_start outside IDLE is ignored.
  - btn_step in RUN, PAUSED or CHECK is ignored.
- Step spacing: eng_step_en is never high on consecutive cycles; at least one CHECK cycle separates moves.
- Boat reference: the pre-step eng_boat is registered on the cycle eng_step_en is asserted.

Optional Feature:
MC_AUTO_LOOP_EN
- Defined: DONE counts HOLD_TICKS tick wraps, then performs an internal restart (eng_reset pulse) followed directly by eng_start, re-entering ARMED with the latched mode. This gives a continuous demo loop; FAULT never auto-loops.
- Undefined: DONE holds indefinitely until btn_restart, and HOLD_TICKS is unused.

Decomposition:
- Package mc_pkg holds:
  - the 3-bit controller state constants;
  - the 2-bit fault code constants;
  - the 4-bit engine state constants IDLE..S12;
  - the constant TOTAL = 3 (missionaries and cannibals per side).
- One sub-module, mc_rule_checker: combinational. Inputs are the bank counts, boat now/prev, valid, done and step number; outputs are pass and code. It is reused by the display/debug logic.
- The tick divider stays inline.

Test Plan:
- Manual run: mode_auto=0, btn_start, then 12 btn_step pulses → 12 eng_step_en pulses; step_count = 12; state DONE; fault = 0.
- Auto pacing: TICK_DIV=4, mode_auto=1, btn_start → eng_step_en pulses exactly 5 cycles apart (4 RUN + 1 CHECK); DONE after 12 pulses.
- Pause: btn_pause at counter = 2 → no eng_step_en for 20 cycles; second btn_pause → next step 2 counts later.
- Unsafe bank: model returns M_left=1, C_left=2, M_right=2, C_right=1 after move 3 → state FAULT, fault_code = 2, no further eng_step_en.
- Conservation beats sequence: after one move, bank sums are 4 and eng_valid = 0 → fault_code = 1. Then btn_restart → eng_reset pulse, fault = 0, IDLE.
- Priority: btn_restart and btn_step in the same cycle in STEP_WAIT → eng_reset asserted, eng_step_en stays 0. With MC_AUTO_LOOP_EN, HOLD_TICKS=2: DONE → eng_start pulse 2 ticks later.
